// File: rtl/cla_share_arb_if.sv
// cla_share_arb_if: bundles the client request/response signals and the shared adder
// connection of cla_share_arb.
//   slave  : arbiter view (receives requests and adder results, drives grants/results/adder)
//   master : environment view (clients plus the shared adder instance)
// Signals:
//   req/req_a/req_b         per-requester request level and 4-bit operands (requester i at [4i+3:4i])
//   gnt                     one-hot one-cycle grant
//   rsp_valid/id/sum/cout   result strobe, owner index, captured sum and carry
//   busy                    arbiter not idle
//   add_start/add_a/add_b   start pulse and operands to the shared adder
//   add_sum/add_cout        shared adder result
interface cla_share_arb_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned ID_W = 2
);
   logic [NREQ-1:0]   req;
   logic [4*NREQ-1:0] req_a;
   logic [4*NREQ-1:0] req_b;
   logic [NREQ-1:0]   gnt;
   logic              rsp_valid;
   logic [ID_W-1:0]   rsp_id;
   logic [3:0]        rsp_sum;
   logic              rsp_cout;
   logic              busy;
   logic              add_start;
   logic [3:0]        add_a;
   logic [3:0]        add_b;
   logic [3:0]        add_sum;
   logic              add_cout;

   modport slave (
      input  req, req_a, req_b, add_sum, add_cout,
      output gnt, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy, add_start, add_a, add_b
   );

   modport master (
      output req, req_a, req_b, add_sum, add_cout,
      input  gnt, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy, add_start, add_a, add_b
   );
endinterface

// File: rtl/cla_share_arb.sv
// cla_share_arb: shares one multi-cycle 4-bit carry-lookahead adder between NREQ requesters.
// A winner is picked in IDLE, granted for one cycle together with a one-cycle adder start
// pulse, the operands are held for WAIT_CYC cycles, then Sum/Cout are captured and returned
// for one cycle tagged with the winner's index. The adder has no done output, so the fixed
// wait is the only completion indication.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset; aborts any operation in flight
//   bus    cla_share_arb_if.slave (requests, grants, results, shared adder connection)
// Configuration macro:
//   CLA_ARB_FIXED_PRIO_EN  defined: fixed priority (lowest index wins), no rotating pointer
//                          undefined: round robin starting at the requester after the last winner
// All outputs are registered.
module cla_share_arb #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned ID_W     = 2,
   parameter int unsigned WAIT_CYC = 10
) (
   input  logic           clk,
   input  logic           rst_n,
   cla_share_arb_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(WAIT_CYC);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ID_W-1:0]   win_q, win_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              add_start_q, add_start_d;
   logic [3:0]        add_a_q, add_a_d;
   logic [3:0]        add_b_q, add_b_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [3:0]        rsp_sum_q, rsp_sum_d;
   logic              rsp_cout_q, rsp_cout_d;
   logic              busy_q, busy_d;

   logic              any_req;
   logic [ID_W-1:0]   pick;
   logic              cnt_done;

   assign any_req  = |bus.req;
   assign cnt_done = (cnt_q == CNT_W'(WAIT_CYC - 1));

`ifdef CLA_ARB_FIXED_PRIO_EN
   // Scan from the top so the lowest requesting index is the last write.
   always_comb begin
      pick = '0;
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         if (bus.req[i]) pick = ID_W'(i);
      end
   end
`else
   logic [ID_W-1:0] ptr_q, ptr_d;
   int              idx;

   // Scan the rotated order from its far end so the first requester at or after ptr wins.
   always_comb begin
      pick = '0;
      idx  = 0;
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         idx = int'(ptr_q) + i;
         if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
         if (bus.req[idx]) pick = ID_W'(idx);
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (state_q == StIdle && any_req) begin
         ptr_d = (pick == ID_W'(NREQ - 1)) ? '0 : pick + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (any_req) state_d = StIssue;
         StIssue: state_d = StWait;
         StWait:  if (cnt_done) state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output/datapath next values; outputs are registered so they line up with the state.
   always_comb begin
      gnt_d       = '0;
      add_start_d = 1'b0;
      rsp_valid_d = 1'b0;
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      cnt_d       = cnt_q;
      win_d       = win_q;
      rsp_id_d    = rsp_id_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_cout_d  = rsp_cout_q;
      busy_d      = (state_d != StIdle);
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               gnt_d       = NREQ'(1) << pick;
               add_start_d = 1'b1;
               win_d       = pick;
               add_a_d     = bus.req_a[4*int'(pick) +: 4];
               add_b_d     = bus.req_b[4*int'(pick) +: 4];
            end
         end
         StIssue: cnt_d = '0;
         StWait: begin
            if (cnt_done) begin
               rsp_valid_d = 1'b1;
               rsp_id_d    = win_q;
               rsp_sum_d   = bus.add_sum;
               rsp_cout_d  = bus.add_cout;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp: ;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q       <= '0;
         add_start_q <= 1'b0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         cnt_q       <= '0;
         win_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_sum_q   <= '0;
         rsp_cout_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         gnt_q       <= gnt_d;
         add_start_q <= add_start_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         cnt_q       <= cnt_d;
         win_q       <= win_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_cout_q  <= rsp_cout_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.add_start = add_start_q;
   assign bus.add_a     = add_a_q;
   assign bus.add_b     = add_b_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_sum   = rsp_sum_q;
   assign bus.rsp_cout  = rsp_cout_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_cla_share_arb.sv
// tb_cla_share_arb: self-checking bench for cla_share_arb. A behavioural adder with an
// 8-cycle start-to-Sum latency stands in for the shared adder; a transaction-level model
// predicts every output cycle by cycle from the grant time of each operation.
module tb_cla_share_arb;
   localparam int unsigned NREQ     = 4;
   localparam int unsigned ID_W     = 2;
   localparam int unsigned WAIT_CYC = 10;
   localparam int          W        = int'(WAIT_CYC);
   localparam int          ADD_LAT  = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   cla_share_arb_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

   cla_share_arb #(.NREQ(NREQ), .ID_W(ID_W), .WAIT_CYC(WAIT_CYC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- requesters ----------------
   logic [3:0]      op_a [NREQ];
   logic [3:0]      op_b [NREQ];
   logic [NREQ-1:0] hold     = '0;
   logic [NREQ-1:0] last_gnt = '0;

   always_comb begin
      for (int i = 0; i < int'(NREQ); i++) begin
         bus.req_a[4*i +: 4] = op_a[i];
         bus.req_b[4*i +: 4] = op_b[i];
      end
   end

   // ---------------- shared adder model ----------------
   logic prev_start = 1'b0;
   int   ad_cnt     = 0;
   initial begin
      bus.add_sum  = 4'h0;
      bus.add_cout = 1'b0;
   end
   always @(posedge clk) begin
      prev_start <= bus.add_start;
      if (bus.add_start && !prev_start) begin
         ad_cnt <= 1;
         // Wrong value until the latency has elapsed.
         {bus.add_cout, bus.add_sum} <= 5'h1F ^ ({1'b0, bus.add_a} + {1'b0, bus.add_b});
      end else if (ad_cnt != 0) begin
         if (ad_cnt == ADD_LAT - 1) begin
            ad_cnt <= 0;
            {bus.add_cout, bus.add_sum} <= {1'b0, bus.add_a} + {1'b0, bus.add_b};
         end else begin
            ad_cnt <= ad_cnt + 1;
         end
      end
   end

   // ---------------- reference model + monitor ----------------
   bit         m_act  = 1'b0;
   int         m_iss  = 0;
   int         m_win  = 0;
   int         m_ptr  = 0;
   logic [3:0] m_a, m_b;
   logic [3:0] m_sum  = '0;
   logic       m_cout = 1'b0;
   int         m_id   = 0;
   int         gnt_log [$];
   int         rsp_log [$];

   function automatic int pick_winner(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < int'(NREQ); k++) begin
         if (r[(p + k) % int'(NREQ)]) return (p + k) % int'(NREQ);
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      int off;
      logic [NREQ-1:0] exp_gnt;
      cyc++;
      last_gnt = bus.gnt;
      if (!rst_n) begin
         m_act = 1'b0; m_ptr = 0; m_sum = '0; m_cout = 1'b0; m_id = 0;
         chk("rst_gnt", 64'(bus.gnt), 64'(0));
         chk("rst_busy", 64'(bus.busy), 64'(0));
         chk("rst_start", 64'(bus.add_start), 64'(0));
         chk("rst_valid", 64'(bus.rsp_valid), 64'(0));
         chk("rst_rsp", 64'({bus.rsp_id, bus.rsp_cout, bus.rsp_sum}), 64'(0));
         chk("rst_ops", 64'({bus.add_a, bus.add_b}), 64'(0));
      end else begin
         off = cyc - m_iss;
         if (m_act && off == W + 1) begin
            m_id = m_win;
            {m_cout, m_sum} = {1'b0, m_a} + {1'b0, m_b};
         end
         exp_gnt = (m_act && off == 0) ? NREQ'(1) << m_win : '0;
         chk("gnt", 64'(bus.gnt), 64'(exp_gnt));
         chk("add_start", 64'(bus.add_start), 64'(m_act && off == 0));
         chk("busy", 64'(bus.busy), 64'(m_act && off <= W + 1));
         chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_act && off == W + 1));
         chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
         chk("rsp_sum", 64'(bus.rsp_sum), 64'(m_sum));
         chk("rsp_cout", 64'(bus.rsp_cout), 64'(m_cout));
         if (m_act && off <= W) begin
            chk("add_a", 64'(bus.add_a), 64'(m_a));
            chk("add_b", 64'(bus.add_b), 64'(m_b));
         end
         if (m_act && off == W + 1) begin
            m_act = 1'b0;
         end else if (!m_act && bus.req != '0) begin
            m_win = pick_winner(bus.req, m_ptr);
`ifndef CLA_ARB_FIXED_PRIO_EN
            m_ptr = (m_win + 1) % int'(NREQ);
`endif
            m_act = 1'b1;
            m_iss = cyc + 1;
            m_a   = op_a[m_win];
            m_b   = op_b[m_win];
         end
      end
      for (int i = 0; i < int'(NREQ); i++) if (bus.gnt[i]) gnt_log.push_back(i);
      if (bus.rsp_valid) rsp_log.push_back(int'(bus.rsp_id));
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (last_gnt[i] && !hold[i]) bus.req[i] = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 40 && bus.busy; n++) tick();
      chk("idle_reached", 64'(bus.busy), 64'(0));
      tick();
   endtask

   typedef struct {
      int         id;
      logic [3:0] a;
      logic [3:0] b;
      int         exp_id;
      logic [3:0] exp_sum;
      logic       exp_cout;
   } vec_t;

   task automatic run_vec(input vec_t v);
      int n;
      op_a[v.id] = v.a;
      op_b[v.id] = v.b;
      bus.req[v.id] = 1'b1;
      for (n = 0; n < 40 && !bus.gnt[v.id]; n++) tick();
      chk("vec_gnt", 64'(bus.gnt), 64'(NREQ'(1) << v.exp_id));
      chk("vec_start_hi", 64'(bus.add_start), 64'(1));
      tick();
      chk("vec_start_pulse", 64'(bus.add_start), 64'(0));
      for (n = 1; n < 40 && !bus.rsp_valid; n++) tick();
      chk("vec_latency", 64'(n), 64'(W + 1));
      chk("vec_rsp_id", 64'(bus.rsp_id), 64'(v.exp_id));
      chk("vec_rsp_sum", 64'(bus.rsp_sum), 64'(v.exp_sum));
      chk("vec_rsp_cout", 64'(bus.rsp_cout), 64'(v.exp_cout));
      tick();
      chk("vec_valid_pulse", 64'(bus.rsp_valid), 64'(0));
      chk("vec_sum_hold", 64'(bus.rsp_sum), 64'(v.exp_sum));
      wait_idle();
   endtask

   task automatic run_held(input logic [NREQ-1:0] mask, input int e0, input int e1);
      do_reset();
      gnt_log.delete();
      hold    = mask;
      bus.req = mask;
      for (int n = 0; n < 200 && gnt_log.size() < 4; n++) tick();
      hold    = '0;
      bus.req = '0;
      for (int k = 0; k < 4; k++) begin
         chk("held_order", 64'(k < gnt_log.size() ? gnt_log[k] : -1), 64'((k % 2 == 0) ? e0 : e1));
      end
      wait_idle();
   endtask

   vec_t tbl [5];

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int aborted;
      tbl[0] = '{id: 2, a: 4'h7, b: 4'h9, exp_id: 2, exp_sum: 4'h0, exp_cout: 1'b1};
      tbl[1] = '{id: 1, a: 4'hF, b: 4'hF, exp_id: 1, exp_sum: 4'hE, exp_cout: 1'b1};
      tbl[2] = '{id: 3, a: 4'h0, b: 4'h0, exp_id: 3, exp_sum: 4'h0, exp_cout: 1'b0};
      tbl[3] = '{id: 0, a: 4'h5, b: 4'h6, exp_id: 0, exp_sum: 4'hB, exp_cout: 1'b0};
      tbl[4] = '{id: 1, a: 4'h3, b: 4'h4, exp_id: 1, exp_sum: 4'h7, exp_cout: 1'b0};

      bus.req = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
      end
      repeat (3) tick();
      rst_n = 1'b1;
      chk("reset_busy", 64'(bus.busy), 64'(0));
      chk("reset_gnt", 64'(bus.gnt), 64'(0));
      tick();

      // Directed single-requester vectors.
      for (int t = 0; t < 4; t++) run_vec(tbl[t]);

      // All four requesting from reset, each dropping after its grant.
      do_reset();
      gnt_log.delete();
      rsp_log.delete();
      for (int i = 0; i < int'(NREQ); i++) begin
         op_a[i] = 4'(i + 1);
         op_b[i] = 4'(3 * i);
      end
      bus.req = '1;
      for (int n = 0; n < 200 && rsp_log.size() < 4; n++) tick();
      for (int k = 0; k < 4; k++) begin
`ifdef CLA_ARB_FIXED_PRIO_EN
         chk("all4_gnt", 64'(k < gnt_log.size() ? gnt_log[k] : -1), 64'(k));
`else
         chk("all4_gnt", 64'(k < gnt_log.size() ? gnt_log[k] : -1), 64'(k));
`endif
         chk("all4_rsp", 64'(k < rsp_log.size() ? rsp_log[k] : -1), 64'(k));
      end
      wait_idle();

      // Continuously held pairs.
`ifdef CLA_ARB_FIXED_PRIO_EN
      run_held(4'b1001, 0, 0);
      run_held(4'b0011, 0, 0);
`else
      run_held(4'b1001, 0, 3);
      run_held(4'b0011, 0, 1);
`endif

      // Reset during WAIT aborts the operation.
      op_a[2] = 4'h1;
      op_b[2] = 4'h2;
      bus.req[2] = 1'b1;
      for (int n = 0; n < 40 && !bus.gnt[2]; n++) tick();
      repeat (4) tick();
      chk("pre_abort_busy", 64'(bus.busy), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 64'(bus.busy), 64'(0));
      chk("abort_ops", 64'({bus.add_a, bus.add_b, bus.add_start}), 64'(0));
      chk("abort_rsp", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout}), 64'(0));
      tick();
      rst_n = 1'b1;
      aborted = 0;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (bus.rsp_valid) aborted++;
      end
      chk("abort_no_rsp", 64'(aborted), 64'(0));
      run_vec(tbl[4]);

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         tick();
         for (int i = 0; i < int'(NREQ); i++) begin
            if (!bus.req[i] && !last_gnt[i] && $urandom_range(0, 5) == 0) begin
               op_a[i] = 4'($urandom);
               op_b[i] = 4'($urandom);
               bus.req[i] = 1'b1;
            end
         end
      end
      bus.req = '0;
      wait_idle();
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
